// File: rtl/cacheline_burst_adapter.sv
// Splits one cache-line read/write into a BEATS-long burst on the memory bus and
// reassembles read beats into a line, answering the cache with a one-cycle resp_o.
//   state | meaning
//   IDLE  | waiting for read_i/write_i (read wins)
//   READ  | read_o high, collecting beats into the assembly buffer
//   WRITE | write_o high, presenting the latched line one beat at a time
//   DONE  | resp_o high for one cycle, counter cleared
module cacheline_burst_adapter #(
  parameter int BURST_W = 64,
  parameter int BEATS   = 4,
  localparam int LINE_W = BURST_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rbuf_q;
  logic [LINE_W-1:0] rline_d;
  logic              last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);
  assign burst_o   = wline_q[int'(cnt_q) * BURST_W +: BURST_W];

  // Assembly buffer with the current beat merged in; line_o only takes it on the last beat
  // so the cache never sees a half-built line.
  always_comb begin
    rline_d = rbuf_q;
    rline_d[int'(cnt_q) * BURST_W +: BURST_W] = burst_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wline_q   <= '0;
      rbuf_q    <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (read_i) begin
            address_o <= address_i & ~OFF_MASK;
            read_o    <= 1'b1;
            state_q   <= READ;
          end else if (write_i) begin
            address_o <= address_i & ~OFF_MASK;
            wline_q   <= line_i;
            write_o   <= 1'b1;
            state_q   <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            rbuf_q <= rline_d;
            cnt_q  <= cnt_q + 1'b1;
            if (last_beat) begin
              line_o  <= rline_d;
              read_o  <= 1'b0;
              resp_o  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized bench for cacheline_burst_adapter: a driver queues expected line
// transactions, a memory responder serves beats, and a monitor scores every cycle.
module tb_cacheline_burst_adapter;

  logic         clk, rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  cacheline_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  typedef struct {
    bit           is_read;
    bit           consec;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  localparam logic [255:0] ALIGNED_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WRITE_LINE   = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one line request for a single IDLE cycle and wait (bounded) for resp_o.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [255:0] l, input bit consec);
    txn_t t;
    int   i;
    @(negedge clk);
    read_i    = rd;
    write_i   = wr;
    address_i = a;
    line_i    = rd ? rand256() : l;
    t.is_read = rd;
    t.consec  = consec;
    t.addr    = a;
    t.line    = l;
    exp_q.push_back(t);
    @(negedge clk);
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = $urandom;
    line_i    = rand256();
    check("start_latency", {read_o, write_o}, rd ? 2'b10 : 2'b01);
    for (i = 0; i < 300 && !resp_o; i++) @(negedge clk);
    if (!resp_o) check("resp_timeout", 1'b0, 1'b1);
  endtask

  // Memory responder: serves read beats from the queued transaction, random wait states.
  initial begin
    int   rbeat;
    bit   acc;
    txn_t t;
    rbeat   = 0;
    acc     = 1'b0;
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rbeat   = 0;
        acc     = 1'b0;
        resp_i  = 1'($urandom % 2);
        burst_i = {$urandom, $urandom};
      end else begin
        if (acc) rbeat++;
        if ((read_o || write_o) && exp_q.size() > 0) begin
          t       = exp_q[0];
          resp_i  = t.consec ? 1'b1 : ($urandom % 3 != 0);
          burst_i = t.is_read ? t.line[64*(rbeat%4) +: 64] : {$urandom, $urandom};
          acc     = resp_i;
        end else begin
          rbeat   = 0;
          acc     = 1'b0;
          resp_i  = ($urandom % 8 == 0);
          burst_i = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: per-cycle bus checks and one scored response per queued transaction.
  initial begin
    txn_t         t;
    int           mbeats, active;
    logic [255:0] last_rd;
    mbeats  = 0;
    active  = 0;
    last_rd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        mbeats  = 0;
        active  = 0;
        last_rd = '0;
      end else begin
        if (read_o || write_o) begin
          if (exp_q.size() == 0) begin
            check("spurious_burst", {read_o, write_o}, 2'b00);
          end else begin
            t = exp_q[0];
            check("direction", {read_o, write_o}, t.is_read ? 2'b10 : 2'b01);
            check("address_o", address_o, t.addr & 32'hFFFF_FFE0);
            if (write_o) check("burst_o", burst_o, t.line[64*(mbeats%4) +: 64]);
            active++;
            if (resp_i) mbeats++;
          end
        end
        if (resp_o) begin
          if (exp_q.size() == 0) begin
            check("spurious_resp", resp_o, 1'b0);
          end else begin
            t = exp_q.pop_front();
            check("beat_count", mbeats, 4);
            if (t.consec) check("active_cycles", active, 4);
            if (t.is_read) last_rd = t.line;
            check("line_o", line_o, last_rd);
          end
          mbeats = 0;
          active = 0;
        end
      end
    end
  end

  // Driver
  initial begin
    txn_t t;
    rst       = 1'b1;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = '0;
    line_i    = '0;

    repeat (6) begin
      @(negedge clk);
      read_i    = 1'($urandom % 2);
      write_i   = 1'($urandom % 2);
      address_i = $urandom;
      line_i    = rand256();
      #1;
      check("reset_outputs", {read_o, write_o, resp_o, address_o, burst_o}, '0);
      check("reset_line_o", line_o, '0);
    end
    @(negedge clk);
    read_i  = 1'b0;
    write_i = 1'b0;
    rst     = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("idle_quiet", {resp_o, read_o, write_o}, 3'b000);
    end

    issue(1'b1, 1'b0, 32'h0000_1234, ALIGNED_LINE, 1'b1);
    check("aligned_line", line_o, ALIGNED_LINE);
    check("aligned_addr", address_o, 32'h0000_1220);

    issue(1'b0, 1'b1, 32'h0000_4444, WRITE_LINE, 1'b0);
    check("write_keeps_line_o", line_o, ALIGNED_LINE);

    issue(1'b1, 1'b1, $urandom, rand256(), 1'b0);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom % 4;
      repeat ($urandom % 3) @(negedge clk);
      issue(k != 2, k >= 2, $urandom, rand256(), ($urandom % 4) == 0);
    end

    // Reset in the middle of a read, after two beats have been accepted.
    @(negedge clk);
    read_i    = 1'b1;
    address_i = 32'h0000_8888;
    t.is_read = 1'b1;
    t.consec  = 1'b1;
    t.addr    = 32'h0000_8888;
    t.line    = rand256();
    exp_q.push_back(t);
    @(negedge clk);
    read_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_read_o", read_o, 1'b0);
    check("rst_mid_line_o", line_o, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1'b1, 1'b0, 32'h0000_1234, ALIGNED_LINE, 1'b1);
    check("post_reset_line", line_o, ALIGNED_LINE);

    // Back-to-back: write starts straight after the read's resp_o.
    issue(1'b1, 1'b0, $urandom, rand256(), 1'b0);
    issue(1'b0, 1'b1, $urandom, rand256(), 1'b0);
    for (int n = 0; n < 20; n++) begin
      issue(($urandom % 2) == 1, 1'b1, $urandom, rand256(), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
